// File: rtl/qnigma_x25519_rd_if.sv
// Result-readout bus for qnigma_x25519_rd.
//   start/busy          : readout trigger from the ECP core, collector busy flag
//   ext_rd_req/ptr      : one-shot read request and register pointer to the ALU
//   ext_rd_val/dat/eof  : ALU word stream, least-significant word first
//   key/key_zero/key_val/key_rdy : assembled key to the protocol layer
//   err                 : one-cycle frame/timeout error pulse
// slave is the collector's view, master the surrounding system's view.
interface qnigma_x25519_rd_if #(
  parameter int W     = 256,
  parameter int WRD_W = 8,
  parameter int PTR_W = 5
);
  logic             start;
  logic             busy;
  logic             ext_rd_req;
  logic [PTR_W-1:0] ext_rd_ptr;
  logic             ext_rd_val;
  logic [WRD_W-1:0] ext_rd_dat;
  logic             ext_rd_eof;
  logic [W-1:0]     key;
  logic             key_zero;
  logic             key_val;
  logic             key_rdy;
  logic             err;

  modport slave (
    input  start, ext_rd_val, ext_rd_dat, ext_rd_eof, key_rdy,
    output busy, ext_rd_req, ext_rd_ptr, key, key_zero, key_val, err
  );

  modport master (
    output start, ext_rd_val, ext_rd_dat, ext_rd_eof, key_rdy,
    input  busy, ext_rd_req, ext_rd_ptr, key, key_zero, key_val, err
  );
endinterface

// File: rtl/qnigma_x25519_rd.sv
// X25519 result collector. On start it requests the u-coordinate register
// from the ALU, shifts the little-endian word stream into a W-bit key,
// flags the all-zero shared secret and offers the key on key_val/key_rdy.
// Malformed frames (short, long) and missing eof raise a one-cycle err.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : qnigma_x25519_rd_if.slave (see interface header)
module qnigma_x25519_rd #(
  parameter int W       = 256,
  parameter int WRD_W   = 8,
  parameter int WORDS   = W / WRD_W,
  parameter int PTR_W   = 5,
  parameter int RES_PTR = 0,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  qnigma_x25519_rd_if.slave bus
);
  localparam int WC_W = $clog2(WORDS + 1);
  localparam int TC_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ, RECV, CHECK, OUT, FAIL} state_t;

  state_t          state;
  logic [WC_W-1:0] wcnt;
  logic [TC_W-1:0] tcnt;
  logic            zacc;  // every word so far was zero
  logic            lerr;  // long frame seen in this readout

  // Word beat bookkeeping; the counter saturates at WORDS so an extra word
  // is recognised as a long frame rather than wrapping.
  logic            beat;
  logic            over;
  logic [WC_W-1:0] wcnt_nx;

  assign beat    = bus.ext_rd_val && (wcnt < WC_W'(WORDS));
  assign over    = bus.ext_rd_val && (wcnt == WC_W'(WORDS));
  assign wcnt_nx = beat ? wcnt + WC_W'(1) : wcnt;

  assign bus.ext_rd_ptr = PTR_W'(RES_PTR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      bus.busy       <= 1'b0;
      bus.ext_rd_req <= 1'b0;
      bus.key_val    <= 1'b0;
      bus.key_zero   <= 1'b0;
      bus.err        <= 1'b0;
      bus.key        <= '0;
      wcnt           <= '0;
      tcnt           <= '0;
      zacc           <= 1'b1;
      lerr           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state          <= REQ;
            bus.busy       <= 1'b1;
            bus.ext_rd_req <= 1'b1;
          end
        end
        REQ: begin
          bus.ext_rd_req <= 1'b0;
          wcnt           <= '0;
          tcnt           <= '0;
          zacc           <= 1'b1;
          lerr           <= 1'b0;
          state          <= RECV;
        end
        RECV: begin
          tcnt <= tcnt + TC_W'(1);
          if (beat) begin
            bus.key <= {bus.ext_rd_dat, bus.key[W-1:WRD_W]};
            zacc    <= zacc & (bus.ext_rd_dat == '0);
            wcnt    <= wcnt_nx;
          end
          if (over) lerr <= 1'b1;
          // eof judges the count including a word arriving on the same beat.
          if (bus.ext_rd_eof) begin
            if (wcnt_nx == WC_W'(WORDS) && !lerr && !over) begin
              state <= CHECK;
            end else begin
              state   <= FAIL;
              bus.err <= 1'b1;
            end
          end else if (tcnt == TC_W'(TIMEOUT - 2)) begin
            // The counter reaches TIMEOUT-1 on this edge; err shows in the
            // same cycle, TIMEOUT cycles after the request.
            state   <= FAIL;
            bus.err <= 1'b1;
          end
        end
        CHECK: begin
          bus.key_zero <= zacc;
          bus.key_val  <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (bus.key_val && bus.key_rdy) begin
            bus.key_val <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        FAIL: begin
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
